// File: rtl/fifo_reader.sv
// FIFO read-port consumer: issues credit-limited read strobes and delivers the
// captured bytes on a valid/ready stream through a 2-entry skid buffer.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_flag,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                state;
    logic [1:0]            buf_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;
    logic [2:0]            credit;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = head;
    assign pop     = m_valid && m_ready;
    assign busy    = inflight || (buf_cnt != 2'd0);

    // Occupancy the buffer will have after this edge; a new read may only be
    // issued if its byte is guaranteed a slot when it lands next cycle.
    assign credit  = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign read_en = (state == RUN) && enable && !empty_flag && (credit < 3'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= STOP;
                STOP: begin
                    if (enable)     state <= RUN;
                    else if (!busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_cnt    <= 2'd0;
            inflight   <= 1'b0;
            head       <= '0;
            tail       <= '0;
            byte_count <= '0;
        end else begin
            inflight <= read_en;
            buf_cnt  <= credit[1:0];
            if (pop) begin
                byte_count <= byte_count + 1'b1;
                if (buf_cnt == 2'd2) begin
                    head <= tail;
                    if (inflight) tail <= data_out;
                end else if (inflight) begin
                    head <= data_out;
                end
            end else if (inflight) begin
                if (buf_cnt == 2'd0) head <= data_out;
                else                 tail <= data_out;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(inflight && !pop && buf_cnt == 2'd2));

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized and directed bench for fifo_reader against a queue-based model
// of the FIFO, the skid buffer and the enable/stop sequencing.
module tb_fifo_reader;
    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          empty_flag;
    logic [DW-1:0] data_out;
    logic          read_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] byte_count;
    logic          busy;

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .empty_flag(empty_flag),
        .data_out(data_out), .read_en(read_en), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .byte_count(byte_count), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo[$];
    logic [7:0] mq[$];
    logic [7:0] delivered[$];
    logic       minf;
    logic [7:0] inf_byte;
    int mode;   // 0 idle, 1 running, 2 stopping
    int mcnt;
    int reads, pops, cyc;
    int first_rd, last_rd, first_pop, last_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo.push_back(v);
        empty_flag = 1'b0;
    endtask

    task automatic clear_phase();
        delivered.delete();
        reads = 0; pops = 0;
        first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
    endtask

    // One clock cycle: inputs are already driven (after a negedge).
    task automatic cycle();
        bit pop, exp_rd, mbusy, acc;
        int occ;
        logic [7:0] dnext;
        #2;
        pop    = (mq.size() > 0) && m_ready;
        occ    = mq.size() + int'(minf) - int'(pop);
        exp_rd = (mode == 1) && enable && (fifo.size() != 0) && (occ < 2);
        mbusy  = minf || (mq.size() > 0);
        chk("read_en", read_en, exp_rd);
        chk("rd_while_empty", read_en && empty_flag, 0);
        chk("m_valid", m_valid, mq.size() > 0);
        if (mq.size() > 0) chk("m_data", m_data, mq[0]);
        chk("busy", busy, mbusy);
        chk("byte_count", byte_count, mcnt);
        @(posedge clk);
        acc = read_en && (fifo.size() != 0);
        if (pop) begin
            delivered.push_back(mq.pop_front());
            mcnt = (mcnt + 1) & MASK;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
        end
        if (minf) mq.push_back(inf_byte);
        minf = exp_rd;
        if (exp_rd) inf_byte = fifo[0];
        if (acc) begin
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            reads++;
            dnext = fifo.pop_front();
        end else begin
            dnext = 8'($urandom);
        end
        case (mode)
            0: if (enable) mode = 1;
            1: if (!enable) mode = 2;
            default: if (enable) mode = 1; else if (!mbusy) mode = 0;
        endcase
        cyc++;
        #1;
        data_out   = dnext;
        empty_flag = (fifo.size() == 0);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_seq(input string name, input int start, input int n);
        chk({name, "_len"}, delivered.size(), n);
        for (int i = 0; i < n && i < delivered.size(); i++)
            chk(name, delivered[i], start + i);
    endtask

    // Asynchronous assert mid-cycle, release at a negedge.
    task automatic async_reset();
        #3 reset = 1'b0;
        #1;
        chk("rst_read_en", read_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_count", byte_count, 0);
        chk("rst_m_data", m_data, 0);
        mq.delete();
        minf = 0; mode = 0; mcnt = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int n, prev;
        reset = 0; enable = 0; m_ready = 0; empty_flag = 1; data_out = 0;
        minf = 0; inf_byte = 0; mode = 0; mcnt = 0; cyc = 0;
        clear_phase();
        @(negedge clk);
        #2;
        chk("init_read_en", read_en, 0);
        chk("init_m_valid", m_valid, 0);
        chk("init_m_data", m_data, 0);
        chk("init_byte_count", byte_count, 0);
        chk("init_busy", busy, 0);
        @(negedge clk);
        reset = 1;

        // Basic drain
        clear_phase();
        for (int i = 0; i < 8; i++) push(8'(i));
        enable = 1; m_ready = 1;
        run(14);
        chk("basic_reads", reads, 8);
        chk("basic_rd_span", last_rd - first_rd, 7);
        chk("basic_pop_span", last_pop - first_pop, 7);
        chk("basic_latency", first_pop - first_rd, 2);
        check_seq("basic_data", 0, 8);
        chk("basic_count", byte_count, 8);
        chk("basic_busy", busy, 0);
        enable = 0;
        run(3);

        // Backpressure
        clear_phase();
        for (int i = 0; i < 8; i++) push(8'(i));
        enable = 1; m_ready = 0;
        run(10);
        chk("bp_reads", reads, 2);
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_data", m_data, 0);
        m_ready = 1;
        run(14);
        chk("bp_reads_total", reads, 8);
        check_seq("bp_data", 0, 8);
        chk("bp_count_wrapped", byte_count, 0);

        // Intermittent source
        clear_phase();
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) push(8'(8'h10 + i / 3));
            cycle();
        end
        run(6);
        check_seq("inter_data", 8'h10, 4);

        // Stop mid-stream
        clear_phase();
        for (int i = 0; i < 8; i++) push(8'(i));
        n = 0;
        while (reads < 3 && n < 20) begin cycle(); n++; end
        chk("stop_reached_3", reads, 3);
        enable = 0;
        run(10);
        check_seq("stop_data", 0, 3);
        chk("stop_fifo_left", fifo.size(), 5);
        chk("stop_busy", busy, 0);
        clear_phase();
        enable = 1;
        run(12);
        check_seq("resume_data", 3, 5);

        // Reset with two bytes buffered
        clear_phase();
        for (int i = 0; i < 8; i++) push(8'(i));
        m_ready = 0;
        run(6);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_busy", busy, 1);
        async_reset();
        clear_phase();
        m_ready = 1;
        run(14);
        check_seq("post_rst_data", 2, 6);

        // Counter wrap over 17 bytes
        async_reset();
        clear_phase();
        for (int i = 0; i < 17; i++) push(8'(8'h40 + i));
        n = 0;
        while (pops < 17 && n < 40) begin
            prev = pops;
            cycle();
            n++;
            if (pops != prev) begin
                if (pops == 15) chk("wrap_15", byte_count, 15);
                if (pops == 16) chk("wrap_16", byte_count, 0);
                if (pops == 17) chk("wrap_17", byte_count, 1);
            end
        end
        chk("wrap_done", pops, 17);

        // Randomized traffic
        clear_phase();
        for (int i = 0; i < 400; i++) begin
            enable  = ($urandom % 8) != 0;
            m_ready = ($urandom % 3) != 0;
            if ($urandom % 2) push(8'($urandom));
            cycle();
        end
        enable = 1; m_ready = 1;
        n = 0;
        while ((fifo.size() != 0 || mq.size() != 0 || minf) && n < 300) begin cycle(); n++; end
        chk("rand_drained", n < 300, 1);
        enable = 0;
        run(3);
        chk("rand_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
